// File: rtl/onchip_mem_arbiter.sv
// ============================================================================
//  onchip_mem_arbiter : two-master Avalon-MM arbiter for one single-port RAM
//  Optional macro MEM_ARB_FIXED_PRIO_EN selects m0 strict priority.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module onchip_mem_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 32,
    parameter int BE_W      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_reset_req
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               rd_vld_q, rd_vld_d;
    logic               rd_id_q, rd_id_d;
    logic               req0, req1;
    logic               gnt0, gnt1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (reset_n && !mem_reset_req) begin
            gnt0 = req0;
            gnt1 = ~req0 & req1;
            if (gnt0) begin
                state_d = ST_OWN0;
                last_d  = 1'b0;
            end else if (gnt1) begin
                state_d = ST_OWN1;
                last_d  = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end
`else
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Owner keeps the RAM until its burst quota is spent or it goes quiet.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (reset_n && !mem_reset_req) begin
            case (state_q)
                ST_OWN0: begin
                    if (req0 && (cnt_q < MAX_CNT)) begin
                        gnt0  = 1'b1;
                        cnt_d = cnt_q + ONE;
                    end else if (req1) begin
                        gnt1    = 1'b1;
                        state_d = ST_OWN1;
                        cnt_d   = ONE;
                        last_d  = 1'b1;
                    end else if (req0) begin
                        gnt0  = 1'b1;
                        cnt_d = ONE;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_OWN1: begin
                    if (req1 && (cnt_q < MAX_CNT)) begin
                        gnt1  = 1'b1;
                        cnt_d = cnt_q + ONE;
                    end else if (req0) begin
                        gnt0    = 1'b1;
                        state_d = ST_OWN0;
                        cnt_d   = ONE;
                        last_d  = 1'b0;
                    end else if (req1) begin
                        gnt1  = 1'b1;
                        cnt_d = ONE;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (req0 && (!req1 || last_q)) begin
                        gnt0    = 1'b1;
                        state_d = ST_OWN0;
                        cnt_d   = ONE;
                        last_d  = 1'b0;
                    end else if (req1) begin
                        gnt1    = 1'b1;
                        state_d = ST_OWN1;
                        cnt_d   = ONE;
                        last_d  = 1'b1;
                    end
                end
            endcase
        end
    end
`endif

    always_comb begin
        mem_chipselect = gnt0 | gnt1;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (gnt0) begin
            mem_write      = m0_write;
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
        end else if (gnt1) begin
            mem_write      = m1_write;
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
        // A simultaneous read+write is treated as a write, so no return beat.
        rd_vld_d = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
        rd_id_d  = gnt1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            rd_vld_q <= 1'b0;
            rd_id_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
        end
    end

    assign m0_waitrequest   = ~gnt0;
    assign m1_waitrequest   = ~gnt1;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = reset_n & rd_vld_q & ~rd_id_q;
    assign m1_readdatavalid = reset_n & rd_vld_q & rd_id_q;
    assign mem_clken        = ~mem_reset_req;

endmodule

`default_nettype wire
